// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: arbitration state and read-owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        LAST_CORE = 2'd0,
        LAST_LDR  = 2'd1,
        LOCKED    = 2'd2
    } arb_state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_LDR  = 1'b1;

endpackage

// File: rtl/mem_arb_rsp_router.sv
// Routes the one-cycle-late memory read data back to the requester that issued the read.
module mem_arb_rsp_router
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_rd_i,
    input  logic                  issue_owner_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  core_rvalid_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    output logic                  ldr_rvalid_o,
    output logic [DATA_WIDTH-1:0] ldr_rdata_o
);

    logic rd_pend_q;
    logic rd_owner_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CORE;
        end else begin
            rd_pend_q  <= issue_rd_i;
            rd_owner_q <= issue_owner_i;
        end
    end

    always_comb begin
        core_rvalid_o = rd_pend_q && (rd_owner_q == OWN_CORE);
        ldr_rvalid_o  = rd_pend_q && (rd_owner_q == OWN_LDR);
        core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
        ldr_rdata_o   = ldr_rvalid_o ? mem_rdata_i : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, zero-latency arbiter sharing the data memory between core and loader.
// Define MEM_ARB_LOCK_EN to enable loader bus lock (bounded by MAX_LOCK grants).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  core_stall_o,
    output logic                  core_rvalid_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    input  logic                  ldr_req_i,
    input  logic                  ldr_we_i,
    input  logic [ADDR_WIDTH-1:0] ldr_addr_i,
    input  logic [DATA_WIDTH-1:0] ldr_wdata_i,
    input  logic                  ldr_lock_i,
    output logic                  ldr_gnt_o,
    output logic                  ldr_rvalid_o,
    output logic [DATA_WIDTH-1:0] ldr_rdata_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    arb_state_t state_q, state_d;
    logic       locked;

`ifdef MEM_ARB_LOCK_EN
    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;

    assign locked = (state_q == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    localparam int unsigned unused_max_lock = MAX_LOCK;
    logic unused_lock;

    assign locked      = 1'b0;
    assign unused_lock = ldr_lock_i;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LAST_LDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are forced low during reset so every output reads 0 while it is held.
    always_comb begin
        core_gnt_o = 1'b0;
        ldr_gnt_o  = 1'b0;
        if (!reset) begin
            if (locked) begin
                ldr_gnt_o = ldr_req_i;
            end else if (core_req_i && ldr_req_i) begin
                if (state_q == LAST_CORE) begin
                    ldr_gnt_o = 1'b1;
                end else begin
                    core_gnt_o = 1'b1;
                end
            end else begin
                core_gnt_o = core_req_i;
                ldr_gnt_o  = ldr_req_i;
            end
        end
    end

    assign core_stall_o = core_req_i && !core_gnt_o && !reset;

    always_comb begin
        state_d = state_q;
`ifdef MEM_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        if (core_gnt_o) begin
            state_d = LAST_CORE;
        end else if (ldr_gnt_o) begin
            state_d = LAST_LDR;
`ifdef MEM_ARB_LOCK_EN
            if (ldr_lock_i) begin
                if (!locked) begin
                    lock_cnt_d = CntW'(1);
                    state_d    = LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q + CntW'(1);
                    // Leaving via LAST_LDR hands the next tie to the core.
                    state_d    = (lock_cnt_q == CntW'(MAX_LOCK - 1)) ? LAST_LDR : LOCKED;
                end
            end
`endif
        end
`ifdef MEM_ARB_LOCK_EN
        else if (locked && !ldr_lock_i) begin
            state_d = LAST_LDR;
        end
`endif
    end

    always_comb begin
        mem_we_o    = (core_gnt_o && core_we_i) || (ldr_gnt_o && ldr_we_i);
        mem_re_o    = (core_gnt_o && !core_we_i) || (ldr_gnt_o && !ldr_we_i);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (core_gnt_o) begin
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end else if (ldr_gnt_o) begin
            mem_addr_o  = ldr_addr_i;
            mem_wdata_o = ldr_wdata_i;
        end
    end

    mem_arb_rsp_router #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_router (
        .clk           (clk),
        .reset         (reset),
        .issue_rd_i    (mem_re_o),
        .issue_owner_i (ldr_gnt_o ? OWN_LDR : OWN_CORE),
        .mem_rdata_i   (mem_rdata_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .ldr_rvalid_o  (ldr_rvalid_o),
        .ldr_rdata_o   (ldr_rdata_o)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-response scoreboard and a behavioural memory.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req_i, core_we_i, core_gnt_o, core_stall_o, core_rvalid_o;
    logic [AW-1:0] core_addr_i;
    logic [DW-1:0] core_wdata_i, core_rdata_o;
    logic          ldr_req_i, ldr_we_i, ldr_lock_i, ldr_gnt_o, ldr_rvalid_o;
    logic [AW-1:0] ldr_addr_i;
    logic [DW-1:0] ldr_wdata_i, ldr_rdata_o;
    logic          mem_we_o, mem_re_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;

    logic [31:0] mem_array [256];
    logic [31:0] model_mem [256];
    rsp_t        rsp_q [$];
    int          checks = 0;
    int          errors = 0;

`ifdef MEM_ARB_LOCK_EN
    localparam logic [6:0] BURST_C = 7'b0010000;
`else
    localparam logic [6:0] BURST_C = 7'b0000010;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_LOCK   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_req_i    (core_req_i),
        .core_we_i     (core_we_i),
        .core_addr_i   (core_addr_i),
        .core_wdata_i  (core_wdata_i),
        .core_gnt_o    (core_gnt_o),
        .core_stall_o  (core_stall_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .ldr_req_i     (ldr_req_i),
        .ldr_we_i      (ldr_we_i),
        .ldr_addr_i    (ldr_addr_i),
        .ldr_wdata_i   (ldr_wdata_i),
        .ldr_lock_i    (ldr_lock_i),
        .ldr_gnt_o     (ldr_gnt_o),
        .ldr_rvalid_o  (ldr_rvalid_o),
        .ldr_rdata_o   (ldr_rdata_o),
        .mem_we_o      (mem_we_o),
        .mem_re_o      (mem_re_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always @(posedge clk) begin
        if (mem_we_o) mem_array[mem_addr_o[7:0]] <= mem_wdata_o;
        if (mem_re_o) mem_rdata_i <= mem_array[mem_addr_o[7:0]];
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o, ldr_gnt_o,
                    ldr_rvalid_o, ldr_rdata_o, mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o},
              192'd0);
    endtask

    // One clock cycle with the currently driven inputs and the expected grants.
    task automatic step(input logic ec, input logic el);
        logic        we, rd;
        logic [31:0] a, d;
        rsp_t        r;
        @(negedge clk);
        check("core_gnt", core_gnt_o, ec);
        check("ldr_gnt", ldr_gnt_o, el);
        check("core_stall", core_stall_o, core_req_i & ~ec);
        we = (ec & core_we_i) | (el & ldr_we_i);
        rd = (ec & ~core_we_i) | (el & ~ldr_we_i);
        a  = ec ? core_addr_i : (el ? ldr_addr_i : 32'd0);
        d  = ec ? core_wdata_i : (el ? ldr_wdata_i : 32'd0);
        check("mem_we", mem_we_o, we);
        check("mem_re", mem_re_o, rd);
        check("mem_addr", mem_addr_o, a);
        check("mem_wdata", mem_wdata_o, d);
        if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            check("core_rvalid", core_rvalid_o, r.owner == 1'b0);
            check("core_rdata", core_rdata_o, (r.owner == 1'b0) ? r.data : 32'd0);
            check("ldr_rvalid", ldr_rvalid_o, r.owner == 1'b1);
            check("ldr_rdata", ldr_rdata_o, (r.owner == 1'b1) ? r.data : 32'd0);
        end else begin
            check("rvalid_idle", {core_rvalid_o, ldr_rvalid_o}, 2'b00);
            check("rdata_idle", {core_rdata_o, ldr_rdata_o}, 64'd0);
        end
        if (we) model_mem[a[7:0]] = d;
        if (rd) begin
            r.owner = el;
            r.data  = model_mem[a[7:0]];
            rsp_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {core_req_i, core_we_i, ldr_req_i, ldr_we_i, ldr_lock_i} = '0;
        core_addr_i = '0; core_wdata_i = '0; ldr_addr_i = '0; ldr_wdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk); #1;
        reset = 1'b0;

        // Loader preloads 0x10, then a core read returns it one cycle later.
        ldr_req_i = 1; ldr_we_i = 1; ldr_addr_i = 32'h10; ldr_wdata_i = 32'hDEADBEEF;
        step(0, 1);
        ldr_req_i = 0;
        core_req_i = 1; core_we_i = 0; core_addr_i = 32'h10;
        step(1, 0);
        core_req_i = 0;
        step(0, 0);

        // Continuous writes from both sides alternate, starting with the loader.
        core_req_i = 1; core_we_i = 1; core_addr_i = 32'h20; core_wdata_i = 32'h1111_0000;
        ldr_req_i  = 1; ldr_we_i  = 1; ldr_addr_i  = 32'h30; ldr_wdata_i  = 32'h2222_0000;
        for (int i = 0; i < 4; i++) begin
            step(i[0], ~i[0]);
            if (i[0]) core_wdata_i = core_wdata_i + 1;
            else      ldr_wdata_i  = ldr_wdata_i + 1;
        end

        // Back-to-back reads: second grant issues alongside the first rvalid.
        core_we_i = 0; ldr_we_i = 0;
        step(0, 1);
        ldr_req_i = 0;
        step(1, 0);
        core_req_i = 0;
        step(0, 0);

        // Lock burst with MAX_LOCK = 4 while the core waits.
        core_req_i = 1; core_we_i = 1; core_addr_i = 32'h40; core_wdata_i = 32'h4040_4040;
        step(1, 0);
        core_addr_i = 32'h44; core_wdata_i = 32'h4444_4444;
        ldr_req_i = 1; ldr_we_i = 1; ldr_lock_i = 1; ldr_addr_i = 32'h50; ldr_wdata_i = 32'h5000;
        for (int s = 0; s < 7; s++) begin
            step(BURST_C[s], ~BURST_C[s]);
            if (BURST_C[s]) begin
                core_req_i = 0;
            end else begin
                ldr_addr_i  = ldr_addr_i + 1;
                ldr_wdata_i = ldr_wdata_i + 1;
            end
        end
        ldr_req_i = 0; ldr_lock_i = 0;
        step(0, 0);

        // Lock released early with the core waiting.
        core_req_i = 1; core_addr_i = 32'h48; core_wdata_i = 32'h4848_4848;
        step(1, 0);
        ldr_req_i = 1; ldr_lock_i = 1; ldr_addr_i = 32'h60; ldr_wdata_i = 32'h6000;
`ifdef MEM_ARB_LOCK_EN
        step(0, 1);
        ldr_addr_i = 32'h61;
        step(0, 1);
        ldr_req_i = 0; ldr_lock_i = 0;
        step(0, 0);
        step(1, 0);
`else
        step(0, 1);
        ldr_req_i = 0; ldr_lock_i = 0;
        step(1, 0);
`endif
        core_req_i = 0;

        // Reset the cycle after a loader read grant: the rvalid must vanish.
        ldr_req_i = 1; ldr_we_i = 0; ldr_addr_i = 32'h30;
        step(0, 1);
        reset = 1; core_req_i = 1; core_we_i = 1;
        rsp_q.delete();
        @(negedge clk);
        check_zero("reset_mid_read_a");
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_mid_read_b");
        core_req_i = 0; ldr_req_i = 0;
        @(posedge clk); #1;
        reset = 0;
        step(0, 0);
        core_req_i = 1; core_addr_i = 32'h70; core_wdata_i = 32'h7070;
        ldr_req_i  = 1; ldr_we_i = 1; ldr_addr_i = 32'h74; ldr_wdata_i = 32'h7474;
        step(1, 0);
        core_req_i = 0;
        step(0, 1);
        ldr_req_i = 0;
        step(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
